// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD counter family: FSM state encoding,
// the largest legal digit, and a per-digit clamp used when loading switches.
package bcd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [3:0] BCD_MAX = 4'd9;

   // Switch inputs can present 4'hA..4'hF; saturate them to 9.
   function automatic logic [3:0] bcd_clamp(input logic [3:0] digit);
      return (digit > BCD_MAX) ? BCD_MAX : digit;
   endfunction

endpackage

// File: rtl/bcd_prescaler.sv
// Free-running divide-by-TICK_DIV strobe generator. tick is a combinational
// terminal-count strobe so the consumer can act on it in the same clock edge.
module bcd_prescaler #(
   parameter int TICK_DIV = 50000000,
   parameter int PW       = 26
) (
   input  logic clock,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

   logic [PW-1:0] count;

   assign tick = en && !clr && (count == LAST);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge clock) begin
      if (!reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= (count == LAST) ? '0 : count + 1'b1;
      end
   end

endmodule

// File: rtl/bcd_countdown_timer.sv
// Two-digit BCD countdown timer: load from switches, count down once per
// prescaled tick, stop at 00 with a sticky done flag. All outputs registered.
module bcd_countdown_timer
   import bcd_pkg::*;
#(
   parameter int TICK_DIV = 50000000,
   parameter int PW       = 26
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       load,
   input  logic [3:0] load_tens,
   input  logic [3:0] load_ones,
   input  logic       start,
   input  logic       pause,
   output logic [3:0] bcd_ones,
   output logic [3:0] bcd_tens,
   output logic       tick,
   output logic       running,
   output logic       done
);

   state_t     state, state_next;
   logic [3:0] ones_next, tens_next;
   logic       tick_next, running_next, done_next;
   logic       pre_clr, pre_en, step;

   // Prescaler restarts on load and on the start edge so the first step
   // lands exactly TICK_DIV cycles after start; it freezes while paused.
   assign pre_clr = load || ((state == ST_IDLE) && start);
   assign pre_en  = (state == ST_RUN) && !pause && !load;

   bcd_prescaler #(
      .TICK_DIV (TICK_DIV),
      .PW       (PW)
   ) u_prescaler (
      .clock (clock),
      .reset (reset),
      .clr   (pre_clr),
      .en    (pre_en),
      .tick  (step)
   );

   // NOTE: every signal driven here receives a default first, so no path
   // leaves a value unassigned and no latch is inferred.
   always_comb begin
      state_next = state;
      ones_next  = bcd_ones;
      tens_next  = bcd_tens;
      done_next  = done;
      tick_next  = 1'b0;

      if (load) begin
         state_next = ST_IDLE;
         ones_next  = bcd_clamp(load_ones);
         tens_next  = bcd_clamp(load_tens);
         done_next  = 1'b0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (start) begin
                  if ((bcd_ones == 4'd0) && (bcd_tens == 4'd0)) begin
                     state_next = ST_DONE;
                     done_next  = 1'b1;
                  end else begin
                     state_next = ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               if (step) begin
                  tick_next = 1'b1;
                  if (bcd_ones == 4'd0) begin
                     ones_next = BCD_MAX;
                     tens_next = bcd_tens - 4'd1;
                  end else begin
                     ones_next = bcd_ones - 4'd1;
                  end
                  if ((bcd_tens == 4'd0) && (bcd_ones == 4'd1)) begin
                     state_next = ST_DONE;
                     done_next  = 1'b1;
                  end
               end
            end
            ST_DONE: begin
            end
            default: begin
               state_next = ST_IDLE;
            end
         endcase
      end

      running_next = (state_next == ST_RUN) && !pause;
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state    <= ST_IDLE;
         bcd_ones <= 4'd0;
         bcd_tens <= 4'd0;
         tick     <= 1'b0;
         running  <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_next;
         bcd_ones <= ones_next;
         bcd_tens <= tens_next;
         tick     <= tick_next;
         running  <= running_next;
         done     <= done_next;
      end
   end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Scoreboard bench: a cycle-level reference model pushes expected outputs,
// a negedge monitor pops and compares them against the timer.
module tb_bcd_countdown_timer;

   localparam int TICK_DIV = 4;
   localparam int PW       = 3;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       load  = 1'b0;
   logic [3:0] load_tens = 4'd0;
   logic [3:0] load_ones = 4'd0;
   logic       start = 1'b0;
   logic       pause = 1'b0;
   logic [3:0] bcd_ones, bcd_tens;
   logic       tick, running, done;

   bcd_countdown_timer #(
      .TICK_DIV (TICK_DIV),
      .PW       (PW)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .load      (load),
      .load_tens (load_tens),
      .load_ones (load_ones),
      .start     (start),
      .pause     (pause),
      .bcd_ones  (bcd_ones),
      .bcd_tens  (bcd_tens),
      .tick      (tick),
      .running   (running),
      .done      (done)
   );

   always #5 clock = ~clock;

   typedef struct {
      int   value;
      logic tick;
      logic done;
      logic running;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   // Reference model: remaining time as a plain integer 0..99.
   localparam int M_STOP = 0, M_COUNT = 1, M_FIN = 2;
   int   m_mode = M_STOP;
   int   m_value = 0;
   int   m_elapsed = 0;
   logic m_done = 1'b0;
   logic m_tick = 1'b0;
   logic m_running = 1'b0;

   task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   function automatic int clamp9(input logic [3:0] d);
      return (d > 4'd9) ? 9 : int'(d);
   endfunction

   task automatic model_update(input logic rs, input logic ld, input logic [3:0] lt,
                               input logic [3:0] lo, input logic st, input logic pa);
      if (!rs) begin
         m_mode = M_STOP; m_value = 0; m_elapsed = 0;
         m_done = 1'b0; m_tick = 1'b0; m_running = 1'b0;
      end else begin
         m_tick = 1'b0;
         if (ld) begin
            m_value = clamp9(lt) * 10 + clamp9(lo);
            m_mode = M_STOP; m_elapsed = 0; m_done = 1'b0;
         end else if (m_mode == M_STOP && st) begin
            if (m_value == 0) begin
               m_mode = M_FIN; m_done = 1'b1;
            end else begin
               m_mode = M_COUNT; m_elapsed = 0;
            end
         end else if (m_mode == M_COUNT && !pa) begin
            m_elapsed++;
            if (m_elapsed == TICK_DIV) begin
               m_elapsed = 0;
               m_value--;
               m_tick = 1'b1;
               if (m_value == 0) begin
                  m_mode = M_FIN; m_done = 1'b1;
               end
            end
         end
         m_running = (m_mode == M_COUNT) && !pa;
      end
   endtask

   // One clock cycle: drive at negedge, model at posedge, queue expectation.
   task automatic step_cycle(input logic rs, input logic ld, input logic [3:0] lt,
                             input logic [3:0] lo, input logic st, input logic pa);
      exp_t e;
      @(negedge clock);
      reset = rs; load = ld; load_tens = lt; load_ones = lo; start = st; pause = pa;
      @(posedge clock);
      model_update(rs, ld, lt, lo, st, pa);
      e.value = m_value; e.tick = m_tick; e.done = m_done; e.running = m_running;
      exp_q.push_back(e);
   endtask

   task automatic idle(input int n, input logic pa);
      for (int i = 0; i < n; i++) step_cycle(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, pa);
   endtask

   task automatic load_val(input logic [3:0] t, input logic [3:0] o);
      step_cycle(1'b1, 1'b1, t, o, 1'b0, 1'b0);
   endtask

   task automatic do_start();
      step_cycle(1'b1, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
   endtask

   always @(negedge clock) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         check("bcd_tens", {4'd0, bcd_tens}, 8'(mon_e.value / 10));
         check("bcd_ones", {4'd0, bcd_ones}, 8'(mon_e.value % 10));
         check("tick",     {7'd0, tick},     {7'd0, mon_e.tick});
         check("done",     {7'd0, done},     {7'd0, mon_e.done});
         check("running",  {7'd0, running},  {7'd0, mon_e.running});
      end
   end

   int cyc;
   logic seen;

   initial begin
      // Reset state
      step_cycle(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
      step_cycle(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
      idle(2, 1'b0);

      // Reset mid-run
      load_val(4'd2, 4'd5); do_start(); idle(10, 1'b0);
      step_cycle(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
      idle(3, 1'b0);

      // Load 12: full run to 00, then a start in DONE is ignored
      load_val(4'd1, 4'd2); do_start(); idle(52, 1'b0);
      do_start(); idle(6, 1'b0);

      // Borrow 10 -> 09
      load_val(4'd1, 4'd0); do_start(); idle(6, 1'b0);

      // Pause for cycles 2..9 after start
      load_val(4'd0, 4'd5); do_start();
      for (int i = 1; i <= 25; i++) idle(1, (i >= 2 && i <= 9));

      // Clamp with load and start together: load wins
      step_cycle(1'b1, 1'b1, 4'hF, 4'hA, 1'b1, 1'b0);
      idle(2, 1'b0); do_start(); idle(6, 1'b0);

      // Zero start, then 03
      load_val(4'd0, 4'd0); do_start(); idle(6, 1'b0);
      load_val(4'd0, 4'd3); do_start(); idle(14, 1'b0);
      do_start(); idle(3, 1'b0);

      // Full 99 -> 00 duration, bounded wait on done
      load_val(4'd9, 4'd9); do_start();
      cyc = 0; seen = 1'b0;
      while (!seen && cyc < 500) begin
         idle(1, 1'b0);
         cyc++;
         #1 seen = done;
      end
      check("full_count_cycles", 8'(cyc / 4), 8'((99 * TICK_DIV) / 4));
      check("full_count_exact", 8'(cyc % 4), 8'((99 * TICK_DIV) % 4));

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         step_cycle(($urandom_range(0, 63) != 0),
                    ($urandom_range(0, 15) == 0),
                    4'($urandom_range(0, 15)),
                    4'($urandom_range(0, 15)),
                    ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 3) == 0));
      end
      // Load a long value occasionally exercised above; finish with a countdown
      load_val(4'd0, 4'd7); do_start(); idle(32, 1'b0);

      @(negedge clock);
      #1;
      check("scoreboard_drained", 8'(exp_q.size()), 8'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
